regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Access controller on the initiator side of the 8×16 register file. It serialises operand-read and writeback requests from the datapath onto the regfile's shared port set, where port A's address doubles as the write address. It also zero-initialises the regfile after reset, because the regfile has no reset of its own. It sits between the decode/writeback logic and the regfile instance.

## Interface
- DATA_W, 16, register width
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W
- WR_STREAK_MAX, 4, maximum consecutive write grants while a read is pending
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- rd_req_valid / rd_req_ready  in / out  1  operand-read request handshake
- rd_req_addr_a, rd_req_addr_b  in  ADDR_W  operand indices
- rd_rsp_valid / rd_rsp_ready  out / in  1  operand response handshake
- rd_rsp_data_a, rd_rsp_data_b  out  DATA_W  operand values
- wr_req_valid / wr_req_ready  in / out  1  writeback handshake
- wr_req_addr  in  ADDR_W; wr_req_data  in  DATA_W  destination and value
- busy  out  1  high during reset and the init sweep
- rf_address_a, rf_address_b  out  ADDR_W  to regfile; rf_address_a is also the write address
- rf_write_enable  out  1; rf_write_data  out  DATA_W  to regfile
- rf_data_a, rf_data_b  in  DATA_W  from regfile, registered by the regfile on posedge

## Operation
- States: S_INIT, S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_CAPT, S_RSP.
- S_INIT:
  - Sweeps idx 0..NREGS-1, one per cycle: rf_address_a=idx, rf_write_enable=1, rf_write_data=0.
  - After the last index, goes to S_IDLE.
  - busy=1 and both req readies are 0.
- S_IDLE:
  - Readies are asserted only here.
  - Arbitration when both valids are high: write wins unless streak==WR_STREAK_MAX, in which case read wins.
  - The ready of the losing side is 0.
  - streak increments on a write grant while rd_req_valid=1. It clears on a read grant, or whenever rd_req_valid=0.
- Write accepted → S_WRITE for exactly one cycle, driving rf_address_a=wr_req_addr, rf_write_data=wr_req_data, rf_write_enable=1. Then S_IDLE.
- Read accepted:
  - S_RD_ISSUE drives rf_address_a/b.
  - S_RD_CAPT: regfile outputs are valid; at the cycle's end they are latched into rd_rsp_data_a/b.
  - S_RSP holds rd_rsp_valid=1 with data stable until rd_rsp_ready=1, then S_IDLE.
- rf_write_enable is 1 only in S_INIT and S_WRITE.
- All rf_* outputs and rsp outputs are registered. Readies are combinational from state, valids and streak.

## Timing
- Reset values: rd_rsp_valid=0, rd_rsp_data_a/b=0, rf_write_enable=0, rf_address_a/b=0, rf_write_data=0, readies=0, busy=1, streak=0, state=S_INIT.
- Init: first write cycle is the cycle after rst deasserts. The sweep lasts NREGS cycles. S_IDLE is entered at cycle NREGS+1.
- Write: accepted at edge T; write_enable high during T..T+1. The regfile commits at the negedge inside that cycle. Controller is back in S_IDLE at T+1.
- Read: accepted at edge T; regfile captures at T+1; rd_rsp_valid rises at T+2. Minimum occupancy is 3 cycles plus stall.
- Read after write: a read accepted at T+1 following a write accepted at T returns the new value.
- Response stall: any number of cycles. No new request is accepted while in S_RSP.
- rst in any state: next state is S_INIT, rd_rsp_valid drops the next cycle, and any in-flight response is discarded.
- rst has priority over every handshake in the same cycle.

## Configuration
- REGFILE_CTRL_R0_ZERO_EN:
  - Defined:
    - Register 0 is hardwired zero.
    - A write to address 0 is accepted and still spends one S_WRITE cycle, but with rf_write_enable=0.
    - Any read operand with address 0 returns 0, regardless of regfile content.
    - The init sweep is unchanged.
  - Undefined: register 0 is an ordinary register.

## Structure
- Package regfile_ctrl_pkg: DATA_W, ADDR_W, NREGS localparams, and the state encoding constants.
- Sub-module regfile_ctrl_arb: write-priority arbiter with the streak counter. Inputs are both valids plus an idle qualifier; outputs are the grants.
- FSM, init index counter and response registers stay in regfile_ctrl.

## Test plan
- Reset/init: rst high 2 cycles, then low → busy=1 for 8 cycles, rf_write_enable high 8 cycles with rf_address_a 0..7 and data 0. Then read (3,6) → 0x0000/0x0000.
- Write r5=0xBEEF, then read (5,3) → rd_rsp_valid exactly 2 cycles after read accept, data_a=0xBEEF, data_b=0x0000.
- Backpressure: rd_rsp_ready low 5 cycles → rsp_valid and data stable, both readies 0. Ready high → S_IDLE next cycle, readies return.
- Contention: both valids held high continuously → grant pattern W,W,W,W,R repeating. Drop rd_req_valid → streak clears.
- Reset mid-S_RSP with r5=0xBEEF → rd_rsp_valid 0 next cycle, init sweep reruns, subsequent read r5 → 0x0000.
- Macro: defined, write r0=0x1234 → no rf_write_enable pulse, read r0 → 0x0000. Undefined → read r0 → 0x1234.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared sizing and FSM state encoding for the regfile access controller.
package regfile_ctrl_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned NREGS         = 2 ** ADDR_W;
  localparam int unsigned WR_STREAK_MAX = 4;
  localparam int unsigned STREAK_W      = $clog2(WR_STREAK_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_WRITE    = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_CAPT  = 3'd4,
    S_RSP      = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_ctrl_arb.sv
// Write-priority arbiter; a pending read wins after WR_STREAK_MAX back-to-back write grants.
module regfile_ctrl_arb
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rd_valid,
  input  logic wr_valid,
  input  logic idle,
  output logic rd_grant_c,
  output logic wr_grant_c
);

  logic [STREAK_W-1:0] streak;
  logic                streak_full;

  always_comb begin
    streak_full = (streak == STREAK_W'(WR_STREAK_MAX));
    wr_grant_c  = idle && wr_valid && !(rd_valid && streak_full);
    rd_grant_c  = idle && rd_valid && (!wr_valid || streak_full);
  end

  // Streak only counts writes that actually made a read wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (rd_grant_c || !rd_valid) begin
      streak <= '0;
    end else if (wr_grant_c) begin
      streak <= streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Initiator-side access controller for the 8x16 regfile: init sweep, read/write serialisation.
// Optional feature: REGFILE_CTRL_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr_a,
  input  logic [ADDR_W-1:0] rd_req_addr_b,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_data_a,
  output logic [DATA_W-1:0] rd_rsp_data_b,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_address_a,
  output logic [ADDR_W-1:0] rf_address_b,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              rd_grant_c;
  logic              wr_grant_c;

  logic              busy_d;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_addr_a_d;
  logic [ADDR_W-1:0] rf_addr_b_d;
  logic [DATA_W-1:0] rf_wdata_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_a_d;
  logic [DATA_W-1:0] rsp_b_d;

  // Reset must block handshakes even in the cycle it is asserted from S_IDLE.
  regfile_ctrl_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .rd_valid   (rd_req_valid),
    .wr_valid   (wr_req_valid),
    .idle       ((state == S_IDLE) && !rst),
    .rd_grant_c (rd_grant_c),
    .wr_grant_c (wr_grant_c)
  );

  assign rd_req_ready = rd_grant_c;
  assign wr_req_ready = wr_grant_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (idx == ADDR_W'(NREGS - 1)) state_nxt = S_IDLE;
      S_IDLE: begin
        if (wr_grant_c)      state_nxt = S_WRITE;
        else if (rd_grant_c) state_nxt = S_RD_ISSUE;
      end
      S_WRITE:    state_nxt = S_IDLE;
      S_RD_ISSUE: state_nxt = S_RD_CAPT;
      S_RD_CAPT:  state_nxt = S_RSP;
      S_RSP:      if (rd_rsp_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_INIT;
    endcase
  end

  // Next-cycle values of the registered outputs; addresses and data hold by default.
  always_comb begin
    busy_d      = 1'b0;
    rf_we_d     = 1'b0;
    rf_addr_a_d = rf_address_a;
    rf_addr_b_d = rf_address_b;
    rf_wdata_d  = rf_write_data;
    rsp_valid_d = rd_rsp_valid;
    rsp_a_d     = rd_rsp_data_a;
    rsp_b_d     = rd_rsp_data_b;
    case (state)
      S_INIT: begin
        busy_d      = 1'b1;
        rf_we_d     = 1'b1;
        rf_addr_a_d = idx;
        rf_wdata_d  = '0;
      end
      S_IDLE: begin
        if (wr_grant_c) begin
          rf_addr_a_d = wr_req_addr;
          rf_wdata_d  = wr_req_data;
`ifdef REGFILE_CTRL_R0_ZERO_EN
          rf_we_d     = (wr_req_addr != '0);
`else
          rf_we_d     = 1'b1;
`endif
        end else if (rd_grant_c) begin
          rf_addr_a_d = rd_req_addr_a;
          rf_addr_b_d = rd_req_addr_b;
        end
      end
      S_RD_CAPT: begin
        rsp_valid_d = 1'b1;
`ifdef REGFILE_CTRL_R0_ZERO_EN
        rsp_a_d     = (rf_address_a == '0) ? '0 : rf_data_a;
        rsp_b_d     = (rf_address_b == '0) ? '0 : rf_data_b;
`else
        rsp_a_d     = rf_data_a;
        rsp_b_d     = rf_data_b;
`endif
      end
      S_RSP: begin
        if (rd_rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      busy            <= 1'b1;
      rf_write_enable <= 1'b0;
      rf_address_a    <= '0;
      rf_address_b    <= '0;
      rf_write_data   <= '0;
      rd_rsp_valid    <= 1'b0;
      rd_rsp_data_a   <= '0;
      rd_rsp_data_b   <= '0;
    end else begin
      idx             <= (state == S_INIT) ? idx + ADDR_W'(1) : '0;
      busy            <= busy_d;
      rf_write_enable <= rf_we_d;
      rf_address_a    <= rf_addr_a_d;
      rf_address_b    <= rf_addr_b_d;
      rf_write_data   <= rf_wdata_d;
      rd_rsp_valid    <= rsp_valid_d;
      rd_rsp_data_a   <= rsp_a_d;
      rd_rsp_data_b   <= rsp_b_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x16 regfile (negedge write, registered read).
module tb_regfile_ctrl;
  import regfile_ctrl_pkg::*;

`ifdef REGFILE_CTRL_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr_a, rd_req_addr_b;
  logic              rd_rsp_valid, rd_rsp_ready;
  logic [DATA_W-1:0] rd_rsp_data_a, rd_rsp_data_b;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic              busy;
  logic [ADDR_W-1:0] rf_address_a, rf_address_b;
  logic              rf_write_enable;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_data_a, rf_data_b;

  logic              poke_en;
  logic [ADDR_W-1:0] poke_addr;
  logic [DATA_W-1:0] poke_data;
  logic [DATA_W-1:0] mem [NREGS] = '{default: 16'hDEAD};

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Regfile model: commits writes at negedge, registers read data at posedge.
  always @(negedge clk) begin
    if (rf_write_enable) mem[rf_address_a] <= rf_write_data;
    if (poke_en)         mem[poke_addr]    <= poke_data;
  end

  always @(posedge clk) begin
    rf_data_a <= mem[rf_address_a];
    rf_data_b <= mem[rf_address_b];
  end

  regfile_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_addr_a   (rd_req_addr_a),
    .rd_req_addr_b   (rd_req_addr_b),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_ready    (rd_rsp_ready),
    .rd_rsp_data_a   (rd_rsp_data_a),
    .rd_rsp_data_b   (rd_rsp_data_b),
    .wr_req_valid    (wr_req_valid),
    .wr_req_ready    (wr_req_ready),
    .wr_req_addr     (wr_req_addr),
    .wr_req_data     (wr_req_data),
    .busy            (busy),
    .rf_address_a    (rf_address_a),
    .rf_address_b    (rf_address_b),
    .rf_write_enable (rf_write_enable),
    .rf_write_data   (rf_write_data),
    .rf_data_a       (rf_data_a),
    .rf_data_b       (rf_data_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_data  = d;
    #1;
    while (!wr_req_ready && n < 50) begin
      tick;
      n++;
    end
    check("wr_ready", 32'(wr_req_ready), 32'd1);
    tick;
    wr_req_valid = 1'b0;
    check("wr_we", 32'(rf_write_enable), (R0Z && a == '0) ? 32'd0 : 32'd1);
    check("wr_addr", 32'(rf_address_a), 32'(a));
    tick;
  endtask

  // Leaves the caller at the first cycle rd_rsp_valid should be high.
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic rsp_rdy);
    int n = 0;
    rd_rsp_ready  = rsp_rdy;
    rd_req_valid  = 1'b1;
    rd_req_addr_a = a;
    rd_req_addr_b = b;
    #1;
    while (!rd_req_ready && n < 50) begin
      tick;
      n++;
    end
    check("rd_ready", 32'(rd_req_ready), 32'd1);
    tick;
    rd_req_valid = 1'b0;
    tick;
    check("rsp_early", 32'(rd_rsp_valid), 32'd0);
    tick;
    check("rsp_lat", 32'(rd_rsp_valid), 32'd1);
  endtask

  task automatic read_check(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                            input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    do_read(a, b, 1'b1);
    check("rsp_a", 32'(rd_rsp_data_a), 32'(ea));
    check("rsp_b", 32'(rd_rsp_data_b), 32'(eb));
    tick;
    check("rsp_done", 32'(rd_rsp_valid), 32'd0);
  endtask

  // pat bit i = 1 means the i-th grant must go to the write side.
  task automatic collect(input int n, input logic [15:0] pat);
    int i = 0;
    int cyc = 0;
    #1;
    while (i < n && cyc < 200) begin
      if (wr_req_ready || rd_req_ready) begin
        check("grant_is_wr", 32'(wr_req_ready), 32'(pat[i]));
        i++;
      end
      tick;
      cyc++;
    end
    check("grant_count", 32'(i), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    rd_req_addr_a = '0; rd_req_addr_b = '0; wr_req_addr = '0; wr_req_data = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    // Reset: register values, and reset blocks handshakes.
    tick;
    tick;
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(rf_write_enable), 32'd0);
    check("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("rst_rd_ready", 32'(rd_req_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_req_ready), 32'd0);
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    rst = 1'b0;

    // Init sweep: 8 zero writes to 0..7.
    for (int i = 0; i < NREGS; i++) begin
      tick;
      check("init_we", 32'(rf_write_enable), 32'd1);
      check("init_addr", 32'(rf_address_a), 32'(i));
      check("init_data", 32'(rf_write_data), 32'd0);
      check("init_busy", 32'(busy), 32'd1);
    end
    tick;
    check("init_done_busy", 32'(busy), 32'd0);
    check("init_done_we", 32'(rf_write_enable), 32'd0);

    read_check(3'd3, 3'd6, 16'h0000, 16'h0000);

    do_write(3'd5, 16'hBEEF);
    read_check(3'd5, 3'd3, 16'hBEEF, 16'h0000);

    // Backpressure: response held while both requesters are refused.
    do_read(3'd5, 3'd5, 1'b0);
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rd_rsp_valid), 32'd1);
      check("bp_data_a", 32'(rd_rsp_data_a), 32'hBEEF);
      check("bp_data_b", 32'(rd_rsp_data_b), 32'hBEEF);
      check("bp_rd_ready", 32'(rd_req_ready), 32'd0);
      check("bp_wr_ready", 32'(wr_req_ready), 32'd0);
      tick;
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    rd_rsp_ready = 1'b1;
    tick;
    check("bp_release", 32'(rd_rsp_valid), 32'd0);
    wr_req_valid = 1'b1;
    #1;
    check("bp_ready_back", 32'(wr_req_ready), 32'd1);
    wr_req_valid = 1'b0;
    #1;

    // Contention: W,W,W,W,R repeating; dropping the read clears the streak.
    wr_req_addr = 3'd1; wr_req_data = 16'h1111;
    rd_req_addr_a = 3'd1; rd_req_addr_b = 3'd2;
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    collect(10, 16'h01EF);
    collect(2, 16'h0003);
    rd_req_valid = 1'b0;
    tick; tick; tick;
    rd_req_valid = 1'b1;
    collect(5, 16'h000F);
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick;

    // Reset in S_RSP discards the response and re-zeroes the file.
    do_write(3'd5, 16'hBEEF);
    do_read(3'd5, 3'd5, 1'b0);
    check("pre_rst_data", 32'(rd_rsp_data_a), 32'hBEEF);
    rst = 1'b1;
    tick;
    check("mid_rst_valid", 32'(rd_rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    rd_rsp_ready = 1'b1;
    n = 0;
    tick;
    while (busy && n < 30) begin
      tick;
      n++;
    end
    check("reinit_busy", 32'(busy), 32'd0);
    read_check(3'd5, 3'd1, 16'h0000, 16'h0000);

    // Register 0 behaviour.
    do_write(3'd0, 16'h1234);
    read_check(3'd0, 3'd0, R0Z ? 16'h0000 : 16'h1234, R0Z ? 16'h0000 : 16'h1234);
    poke_addr = 3'd0; poke_data = 16'hA5A5; poke_en = 1'b1;
    tick;
    poke_en = 1'b0;
    read_check(3'd0, 3'd5, R0Z ? 16'h0000 : 16'hA5A5, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
